// File: rtl/acs_node.sv
// Add-compare-select node for one trellis state of a Viterbi decoder.
// Tracks a saturating, normalisable path metric and its survivor decision over one frame.
module acs_node #(
    parameter int PM_W          = 8,
    parameter int FRAME_LEN     = 64,
    parameter int IS_ZERO_STATE = 0,
    parameter int INIT_BIAS     = 2 ** (PM_W - 2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [1:0]      path_0_bmc,
    input  logic [1:0]      path_1_bmc,
    input  logic [PM_W-1:0] pm_in0,
    input  logic [PM_W-1:0] pm_in1,
    input  logic            norm,
    output logic [PM_W-1:0] pm_out,
    output logic            pm_msb,
    output logic            decision,
    output logic            out_valid,
    output logic            busy,
    output logic            done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [PM_W:0]   HALF_PM   = {2'b01, {(PM_W - 1){1'b0}}};
    localparam logic [PM_W:0]   MAX_PM    = {1'b0, {PM_W{1'b1}}};
    localparam logic [PM_W-1:0] INIT_PM   = (IS_ZERO_STATE != 0) ? '0 : PM_W'(INIT_BIAS);
    localparam logic [15:0]     LAST_STEP = 16'(FRAME_LEN - 1);

    state_t          state;
    state_t          next_state;
    logic [15:0]     step_cnt;
    logic            accept;
    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic            sel;
    logic [PM_W:0]   sel_sum;
    logic [PM_W:0]   norm_sum;
    logic [PM_W-1:0] pm_next;

    // The done cycle is still RUN (busy high) but accepts nothing; the FSM leaves RUN after it.
    assign accept = (state == RUN) && in_valid && !start && !done;

    always_comb begin
        sum0     = {1'b0, pm_in0} + {{(PM_W - 1){1'b0}}, path_0_bmc};
        sum1     = {1'b0, pm_in1} + {{(PM_W - 1){1'b0}}, path_1_bmc};
        sel      = (sum1 < sum0);
        sel_sum  = sel ? sum1 : sum0;
        norm_sum = sel_sum;
        if (norm) begin
            norm_sum = (sel_sum >= HALF_PM) ? (sel_sum - HALF_PM) : '0;
        end
        pm_next = (norm_sum > MAX_PM) ? MAX_PM[PM_W-1:0] : norm_sum[PM_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = RUN;
        end else if ((state == RUN) && done) begin
            next_state = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm_out    <= '0;
            decision  <= 1'b0;
            step_cnt  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= accept;
            done      <= accept && (step_cnt == LAST_STEP);
            if (start) begin
                pm_out   <= INIT_PM;
                decision <= 1'b0;
                step_cnt <= '0;
            end else if (accept) begin
                pm_out   <= pm_next;
                decision <= sel;
                step_cnt <= step_cnt + 16'd1;
            end
        end
    end

    assign pm_msb = pm_out[PM_W-1];
    assign busy   = (state == RUN);

endmodule

// File: tb/tb_acs_node.sv
// Scoreboard bench for acs_node (PM_W=8, FRAME_LEN=4): stimulus queues expected results,
// a negedge monitor pops and compares whenever the node presents out_valid or done.
module tb_acs_node;

    typedef struct {
        logic [7:0] pm;
        logic       dec;
        logic       dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [1:0] path_0_bmc;
    logic [1:0] path_1_bmc;
    logic [7:0] pm_in0;
    logic [7:0] pm_in1;
    logic       norm;
    logic [7:0] pm_out;
    logic       pm_msb;
    logic       decision;
    logic       out_valid;
    logic       busy;
    logic       done;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    exp_t exp_q[$];

    acs_node #(
        .PM_W(8),
        .FRAME_LEN(4),
        .IS_ZERO_STATE(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .path_0_bmc(path_0_bmc),
        .path_1_bmc(path_1_bmc),
        .pm_in0(pm_in0),
        .pm_in1(pm_in1),
        .norm(norm),
        .pm_out(pm_out),
        .pm_msb(pm_msb),
        .decision(decision),
        .out_valid(out_valid),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] pm, input logic dec, input logic dn);
        exp_t e;
        e.pm  = pm;
        e.dec = dec;
        e.dn  = dn;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic with_valid);
        start    = 1'b1;
        in_valid = with_valid;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic step(input logic [7:0] p0, input logic [1:0] b0,
                        input logic [7:0] p1, input logic [1:0] b1, input logic n);
        pm_in0     = p0;
        path_0_bmc = b0;
        pm_in1     = p1;
        path_1_bmc = b1;
        norm       = n;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        norm     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && (out_valid || done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_valid", {31'd0, out_valid}, 32'd1);
                check("pm_out", {24'd0, pm_out}, {24'd0, e.pm});
                check("pm_msb", {31'd0, pm_msb}, {31'd0, e.pm[7]});
                check("decision", {31'd0, decision}, {31'd0, e.dec});
                check("done", {31'd0, done}, {31'd0, e.dn});
                check("busy_with_out", {31'd0, busy}, 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        path_0_bmc = 2'd0;
        path_1_bmc = 2'd0;
        pm_in0     = 8'd0;
        pm_in1     = 8'd0;
        norm       = 1'b0;
        #2;
        check("rst_pm_out", {24'd0, pm_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Frame 1: start right after reset release, four back-to-back steps
        do_start(1'b0);
        check("start_pm_out", {24'd0, pm_out}, 32'd64);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_out_valid", {31'd0, out_valid}, 32'd0);
        expect_out(8'd11, 1'b1, 1'b0);
        step(8'd10, 2'd2, 8'd11, 2'd0, 1'b0);
        expect_out(8'd6, 1'b0, 1'b0);
        step(8'd5, 2'd1, 8'd4, 2'd2, 1'b0);
        expect_out(8'd255, 1'b0, 1'b0);
        step(8'd255, 2'd2, 8'd255, 2'd2, 1'b0);
        expect_out(8'd73, 1'b0, 1'b1);
        step(8'd200, 2'd1, 8'd210, 2'd0, 1'b1);
        // Fifth step lands on the done cycle, sixth in IDLE: both ignored
        step(8'd1, 2'd0, 8'd1, 2'd0, 1'b0);
        step(8'd2, 2'd0, 8'd2, 2'd0, 1'b0);
        idle(2);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_hold_pm", {24'd0, pm_out}, 32'd73);

        // Frame 2: normalisation floor, gap between steps does not count
        do_start(1'b0);
        expect_out(8'd0, 1'b0, 1'b0);
        step(8'd99, 2'd1, 8'd120, 2'd0, 1'b1);
        expect_out(8'd22, 1'b1, 1'b0);
        step(8'd200, 2'd2, 8'd150, 2'd0, 1'b1);
        idle(1);
        check("gap_busy", {31'd0, busy}, 32'd1);
        expect_out(8'd32, 1'b1, 1'b0);
        step(8'd40, 2'd0, 8'd30, 2'd2, 1'b0);
        expect_out(8'd0, 1'b0, 1'b1);
        step(8'd0, 2'd0, 8'd0, 2'd0, 1'b0);
        idle(2);
        check("frame2_busy", {31'd0, busy}, 32'd0);

        // Frame 3: aborted by reset after two steps
        do_start(1'b0);
        expect_out(8'd21, 1'b0, 1'b0);
        step(8'd20, 2'd1, 8'd30, 2'd0, 1'b0);
        expect_out(8'd9, 1'b1, 1'b0);
        step(8'd8, 2'd2, 8'd9, 2'd0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_pm_out", {24'd0, pm_out}, 32'd0);
        check("abort_pm_msb", {31'd0, pm_msb}, 32'd0);
        check("abort_decision", {31'd0, decision}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'd1, 2'd0, 8'd1, 2'd0, 1'b0);
        step(8'd1, 2'd0, 8'd1, 2'd0, 1'b0);
        idle(1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Frame 4: start and in_valid together, then a full frame
        do_start(1'b1);
        check("start_valid_out_valid", {31'd0, out_valid}, 32'd0);
        check("start_valid_pm_out", {24'd0, pm_out}, 32'd64);
        expect_out(8'd3, 1'b0, 1'b0);
        step(8'd3, 2'd0, 8'd7, 2'd0, 1'b0);
        expect_out(8'd6, 1'b1, 1'b0);
        step(8'd7, 2'd2, 8'd5, 2'd1, 1'b0);
        expect_out(8'd1, 1'b1, 1'b0);
        step(8'd0, 2'd2, 8'd0, 2'd1, 1'b0);
        expect_out(8'd15, 1'b0, 1'b1);
        step(8'd15, 2'd0, 8'd15, 2'd0, 1'b0);
        idle(3);
        check("final_busy", {31'd0, busy}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
